// File: rtl/m4_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : m4_sync_counter
// Brief    : Mod-4 synchronous up-counter, 0 -> 1 -> 2 -> 3 -> 0, sync active-low reset
// Revision : 1.0
// ============================================================================
module m4_sync_counter (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] op
);

    localparam logic [1:0] C_RESET_VALUE = 2'b00;

    logic [1:0] r_count;
    logic [1:0] w_count_next;

    // Two-bit binary increment; the carry out of bit 1 is dropped, giving the wrap
    assign w_count_next = {r_count[1] ^ r_count[0], ~r_count[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= C_RESET_VALUE;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign op = r_count;

endmodule
`default_nettype wire

// File: tb/tb_m4_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m4_sync_counter
// Brief    : Directed plus randomized self-checking bench for m4_sync_counter
// Revision : 1.0
// ============================================================================
module tb_m4_sync_counter;

    logic       clk;
    logic       rst_n;
    logic [1:0] op;

    int checks;
    int errors;
    int n_since_reset;

    m4_sync_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Reference: the count is the number of non-reset edges since the last reset edge, mod 4
    function automatic logic [1:0] expected_op();
        return 2'(n_since_reset % 4);
    endfunction

    task automatic check(input string tag);
        logic [1:0] exp;
        exp = expected_op();
        checks++;
        assert (op === exp)
        else begin
            errors++;
            $error("FAIL %s: op=%0d expected=%0d at t=%0t", tag, op, exp, $time);
        end
    endtask

    // Called just after an edge; applies r for the next edge and checks 1 time unit after it
    task automatic step(input logic r, input string tag);
        rst_n = r;
        @(posedge clk);
        if (!r) n_since_reset = 0;
        else    n_since_reset++;
        #1;
        check(tag);
    endtask

    // Reset pulse that lives entirely between two rising edges
    task automatic glitch();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        n_since_reset = 0;
        rst_n         = 1'b1;

        // Reset from unknown: rst_n low over 3..7, edge at t=6
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_from_x");
        rst_n = 1'b1;
        #2;
        check("reset_hold_between_edges");

        // Count after release and wrap, through t=50
        for (int i = 0; i < 11; i++) step(1'b1, "count_wrap");

        // Mid-count reset with op = 2
        while (expected_op() != 2'd2) step(1'b1, "advance_to_2");
        step(1'b0, "midcount_reset");
        for (int i = 0; i < 4; i++) step(1'b1, "resume_after_reset");

        // Reset pulse between edges must be invisible
        for (int i = 0; i < 5; i++) begin
            glitch();
            step(1'b1, "glitch_ignored");
        end

        // Reset held for three edges starting from op = 3
        while (expected_op() != 2'd3) step(1'b1, "advance_to_3");
        for (int i = 0; i < 3; i++) step(1'b0, "reset_held");
        step(1'b1, "release_after_hold");

        // Randomized: occasional reset edges and between-edge glitches
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) glitch();
            step(($urandom_range(0, 6) != 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
